// File: rtl/backprop_sequencer.sv
// rtl/backprop_sequencer.sv - layer-by-layer scheduler for the error_propagator datapath
// Optional feature: define BACKPROP_SEQ_CYCLE_COUNT_EN to add the pass_cycles counter output.
module backprop_sequencer #(
  parameter int MATRIX_WIDTH     = 4,
  parameter int MATRIX_HEIGHT    = 5,
  parameter int DELTA_CELL_WIDTH = 12,
  parameter int LAYER_ADDR_WIDTH = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  output logic                                      start_ready,
  input  logic [LAYER_ADDR_WIDTH-1:0]               start_layer,
  input  logic [MATRIX_WIDTH*DELTA_CELL_WIDTH-1:0]  start_delta,
  output logic [LAYER_ADDR_WIDTH-1:0]               layer,
  output logic                                      layer_valid,
  input  logic                                      layer_ready,
  output logic [MATRIX_WIDTH*DELTA_CELL_WIDTH-1:0]  delta_input,
  output logic                                      delta_input_valid,
  input  logic                                      delta_input_ready,
  input  logic [MATRIX_HEIGHT*DELTA_CELL_WIDTH-1:0] delta_output,
  input  logic                                      delta_output_valid,
  output logic                                      delta_output_ready,
  input  logic                                      error,
  output logic [MATRIX_HEIGHT*DELTA_CELL_WIDTH-1:0] result,
  output logic [LAYER_ADDR_WIDTH-1:0]               result_layer,
  output logic                                      result_valid,
  input  logic                                      result_ready,
  output logic                                      done,
  output logic                                      fault
`ifdef BACKPROP_SEQ_CYCLE_COUNT_EN
  ,
  output logic [15:0]                               pass_cycles
`endif
);

  localparam int DW = MATRIX_WIDTH * DELTA_CELL_WIDTH;
  localparam int OW = MATRIX_HEIGHT * DELTA_CELL_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_LAYER,
    S_ISSUE_DELTA,
    S_WAIT_OUT,
    S_EMIT,
    S_DONE,
    S_FAULT
  } state_t;

  state_t                      state;
  state_t                      nxt;
  logic [LAYER_ADDR_WIDTH-1:0] cur_layer;
  logic [DW-1:0]               cur_delta;

  logic start_xfer;
  logic layer_xfer;
  logic din_xfer;
  logic dout_xfer;
  logic res_xfer;
  logic err_hit;

  // Transfers use the registered valid/ready outputs, so each one implies the state.
  assign start_xfer = start & start_ready;
  assign layer_xfer = layer_valid & layer_ready;
  assign din_xfer   = delta_input_valid & delta_input_ready;
  assign dout_xfer  = delta_output_ready & delta_output_valid;
  assign res_xfer   = result_valid & result_ready;
  assign err_hit    = error & (state != S_IDLE) & (state != S_FAULT);

  assign layer       = cur_layer;
  assign delta_input = cur_delta;

  always_comb begin
    nxt = state;
    if (err_hit) begin
      nxt = S_FAULT;
    end else begin
      case (state)
        S_IDLE:        if (start_xfer) nxt = S_ISSUE_LAYER;
        S_ISSUE_LAYER: if (layer_xfer) nxt = S_ISSUE_DELTA;
        S_ISSUE_DELTA: if (din_xfer)   nxt = S_WAIT_OUT;
        S_WAIT_OUT:    if (dout_xfer)  nxt = S_EMIT;
        S_EMIT:        if (res_xfer)   nxt = (cur_layer == '0) ? S_DONE : S_ISSUE_LAYER;
        S_DONE:        nxt = S_IDLE;
        S_FAULT:       nxt = S_FAULT;
        default:       nxt = S_IDLE;
      endcase
    end
  end

  // Handshake flags are registered from the next state so no input reaches an output combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= S_IDLE;
      start_ready        <= 1'b1;
      layer_valid        <= 1'b0;
      delta_input_valid  <= 1'b0;
      delta_output_ready <= 1'b0;
      result_valid       <= 1'b0;
      done               <= 1'b0;
      fault              <= 1'b0;
      cur_layer          <= '0;
      cur_delta          <= '0;
      result             <= '0;
      result_layer       <= '0;
    end else begin
      state              <= nxt;
      start_ready        <= (nxt == S_IDLE);
      layer_valid        <= (nxt == S_ISSUE_LAYER);
      delta_input_valid  <= (nxt == S_ISSUE_DELTA);
      delta_output_ready <= (nxt == S_WAIT_OUT);
      result_valid       <= (nxt == S_EMIT);
      done               <= (nxt == S_DONE);
      fault              <= (nxt == S_FAULT);
      if (!err_hit) begin
        if (start_xfer) begin
          cur_layer <= start_layer;
          cur_delta <= start_delta;
        end
        if (dout_xfer) begin
          result       <= delta_output;
          result_layer <= cur_layer;
        end
        // Low cells of the emitted result seed the next layer down; upper cells are dropped.
        if (res_xfer && (cur_layer != '0)) begin
          cur_layer <= cur_layer - 1'b1;
          cur_delta <= result[DW-1:0];
        end
      end
    end
  end

`ifdef BACKPROP_SEQ_CYCLE_COUNT_EN
  logic counting;
  assign counting = (state != S_IDLE) & (state != S_DONE) & (state != S_FAULT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pass_cycles <= '0;
    end else if (start_xfer) begin
      pass_cycles <= '0;
    end else if (counting && (pass_cycles != 16'hFFFF)) begin
      pass_cycles <= pass_cycles + 16'd1;
    end
  end
`endif

  logic unused_ok;
  assign unused_ok = &{1'b0, (OW > 0)};

endmodule

// File: tb/tb_backprop_sequencer.sv
// tb/tb_backprop_sequencer.sv - self-checking bench for backprop_sequencer
// Propagator modelled in the bench; expected issues/results pushed to scoreboard queues.
module tb_backprop_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        start_ready;
  logic [1:0]  start_layer;
  logic [47:0] start_delta;
  logic [1:0]  layer;
  logic        layer_valid;
  logic        layer_ready;
  logic [47:0] delta_input;
  logic        delta_input_valid;
  logic        delta_input_ready;
  logic [59:0] delta_output;
  logic        delta_output_valid;
  logic        delta_output_ready;
  logic        error;
  logic [59:0] result;
  logic [1:0]  result_layer;
  logic        result_valid;
  logic        result_ready;
  logic        done;
  logic        fault;
`ifdef BACKPROP_SEQ_CYCLE_COUNT_EN
  logic [15:0] pass_cycles;
`endif

  logic ovr_en;

  backprop_sequencer dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .start_ready        (start_ready),
    .start_layer        (start_layer),
    .start_delta        (start_delta),
    .layer              (layer),
    .layer_valid        (layer_valid),
    .layer_ready        (layer_ready),
    .delta_input        (delta_input),
    .delta_input_valid  (delta_input_valid),
    .delta_input_ready  (delta_input_ready),
    .delta_output       (delta_output),
    .delta_output_valid (delta_output_valid),
    .delta_output_ready (delta_output_ready),
    .error              (error),
    .result             (result),
    .result_layer       (result_layer),
    .result_valid       (result_valid),
    .result_ready       (result_ready),
    .done               (done),
    .fault              (fault)
`ifdef BACKPROP_SEQ_CYCLE_COUNT_EN
    ,
    .pass_cycles        (pass_cycles)
`endif
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int done_cnt = 0;
  logic [47:0] last_din0;

  logic [1:0]  exp_layer_q[$];
  logic [47:0] exp_din_q[$];
  logic [61:0] exp_res_q[$];

  typedef struct {
    logic [1:0]  sl;
    logic [47:0] sd;
    logic        ovr;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[4];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Propagator stand-in: each output cell is a fixed function of the issued layer and delta.
  function automatic logic [59:0] prop_out(input logic [1:0] l, input logic [47:0] d, input logic ovr);
    logic [59:0] o;
    logic [11:0] c;
    if (ovr && l == 2'd1) return {12'd50, 12'd40, 12'd30, 12'd20, 12'd10};
    for (int i = 0; i < 5; i++) begin
      c = d[(i % 4) * 12 +: 12];
      o[i * 12 +: 12] = c * 12'd3 + 12'(l) * 12'd16 + 12'(i);
    end
    return o;
  endfunction

  assign delta_output = prop_out(layer, delta_input, ovr_en);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic bad(input string name);
    total_cnt++;
    $display("FAIL %s: got unexpected transfer expected none", name);
  endtask

  task automatic push_model(input logic [1:0] sl, input logic [47:0] sd, input logic ovr);
    logic [47:0] d;
    logic [59:0] o;
    d = sd;
    for (int l = int'(sl); l >= 0; l--) begin
      exp_layer_q.push_back(2'(l));
      exp_din_q.push_back(d);
      o = prop_out(2'(l), d, ovr);
      exp_res_q.push_back({2'(l), o});
      d = o[47:0];
    end
  endtask

  task automatic flush_q();
    exp_layer_q.delete();
    exp_din_q.delete();
    exp_res_q.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [1:0] sl, input logic [47:0] sd);
    start_layer = sl;
    start_delta = sd;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Cycle count includes the start cycle as 1; done is expected in cycle 4*(L+1)+1.
  task automatic wait_done(input int lim, output int cyc);
    cyc = 1;
    while (!done && cyc < lim) begin
      step();
      cyc++;
    end
  endtask

  // Scoreboard monitor: values stable at negedge are what the next rising edge transfers.
  initial begin
    logic [1:0]  el;
    logic [47:0] ed;
    logic [61:0] er;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (done) done_cnt++;
        if (layer_valid && layer_ready) begin
          if (exp_layer_q.size() == 0) bad("layer_xfer");
          else begin
            el = exp_layer_q.pop_front();
            chk("layer", 64'(layer), 64'(el));
          end
        end
        if (delta_input_valid && delta_input_ready) begin
          if (layer == 2'd0) last_din0 = delta_input;
          if (exp_din_q.size() == 0) bad("delta_input_xfer");
          else begin
            ed = exp_din_q.pop_front();
            chk("delta_input", 64'(delta_input), 64'(ed));
          end
        end
        if (result_valid && result_ready) begin
          if (exp_res_q.size() == 0) bad("result_xfer");
          else begin
            er = exp_res_q.pop_front();
            chk("result", 64'(result), 64'(er[59:0]));
            chk("result_layer", 64'(result_layer), 64'(er[61:60]));
          end
        end
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int cyc;
    push_model(v.sl, v.sd, v.ovr);
    ovr_en = v.ovr;
    done_cnt = 0;
    pulse_start(v.sl, v.sd);
    wait_done(300, cyc);
    chk("done_cycle", 64'(cyc), 64'(v.exp_cyc));
`ifdef BACKPROP_SEQ_CYCLE_COUNT_EN
    chk("pass_cycles", 64'(pass_cycles), 64'(4 * (int'(v.sl) + 1)));
`endif
    step();
    chk("done_one_cycle", 64'(done), 64'(0));
    chk("ready_after_done", 64'(start_ready), 64'(1));
    chk("done_pulses", 64'(done_cnt), 64'(1));
    chk("queues_drained", 64'(exp_layer_q.size() + exp_din_q.size() + exp_res_q.size()), 64'(0));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_start_ready"}, 64'(start_ready), 64'(1));
    chk({tag, "_flags"}, 64'({layer_valid, delta_input_valid, delta_output_ready,
                              result_valid, done, fault}), 64'(0));
    chk({tag, "_layer"}, 64'(layer), 64'(0));
    chk({tag, "_delta_input"}, 64'(delta_input), 64'(0));
    chk({tag, "_result"}, 64'(result), 64'(0));
    chk({tag, "_result_layer"}, 64'(result_layer), 64'(0));
  endtask

  initial begin
    int          cyc;
    logic        ok;
    logic [59:0] held;

    vecs[0] = '{2'd2, {12'd1, 12'd1, 12'd1, 12'd1}, 1'b0, 13};
    vecs[1] = '{2'd0, {12'h123, 12'h456, 12'h789, 12'hABC}, 1'b0, 5};
    vecs[2] = '{2'd3, {12'h010, 12'hFFF, 12'h800, 12'h001}, 1'b0, 17};
    vecs[3] = '{2'd1, {12'd5, 12'd6, 12'd7, 12'd8}, 1'b1, 9};

    rst = 1'b0;
    start = 1'b0;
    start_layer = '0;
    start_delta = '0;
    layer_ready = 1'b1;
    delta_input_ready = 1'b1;
    delta_output_valid = 1'b1;
    result_ready = 1'b1;
    error = 1'b0;
    ovr_en = 1'b0;
    last_din0 = '0;
    repeat (2) step();
    chk_reset_outs("reset");
    rst = 1'b1;
    step();

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);
    chk("feedback_din", 64'(last_din0), 64'({12'd40, 12'd30, 12'd20, 12'd10}));
    ovr_en = 1'b0;

    // Back-pressure: hold result_ready low in EMIT of the top layer.
    push_model(2'd1, {12'd9, 12'd8, 12'd7, 12'd6}, 1'b0);
    result_ready = 1'b0;
    pulse_start(2'd1, {12'd9, 12'd8, 12'd7, 12'd6});
    cyc = 0;
    while (!result_valid && cyc < 50) begin
      step();
      cyc++;
    end
    chk("bp_reach_emit", 64'(result_valid), 64'(1));
    held = result;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (result !== held || !result_valid || layer_valid) ok = 1'b0;
    end
    chk("bp_stalled", 64'(ok), 64'(1));
    result_ready = 1'b1;
    step();
    chk("bp_next_layer_valid", 64'(layer_valid), 64'(1));
    chk("bp_next_layer_idx", 64'(layer), 64'(0));
    wait_done(100, cyc);
    chk("bp_done", 64'(done), 64'(1));
    step();

    // Fault in WAIT_OUT, raised together with delta_output_valid: fault must win.
    push_model(2'd2, {12'd3, 12'd3, 12'd3, 12'd3}, 1'b0);
    delta_output_valid = 1'b0;
    pulse_start(2'd2, {12'd3, 12'd3, 12'd3, 12'd3});
    cyc = 0;
    while (!delta_output_ready && cyc < 20) begin
      step();
      cyc++;
    end
    chk("fault_reach_wait", 64'(delta_output_ready), 64'(1));
    held = result;
    error = 1'b1;
    delta_output_valid = 1'b1;
    step();
    error = 1'b0;
    chk("fault_flag", 64'(fault), 64'(1));
    chk("fault_handshakes", 64'({start_ready, layer_valid, delta_input_valid,
                                 delta_output_ready, result_valid, done}), 64'(0));
    chk("fault_no_capture", 64'(result), 64'(held));
    start = 1'b1;
    repeat (3) step();
    start = 1'b0;
    chk("fault_sticky", 64'(fault), 64'(1));
    chk("fault_start_ignored", 64'({start_ready, layer_valid}), 64'(0));
    rst = 1'b0;
    #1;
    chk("fault_cleared", 64'(fault), 64'(0));
    chk("fault_rst_ready", 64'(start_ready), 64'(1));
    flush_q();
    step();
    rst = 1'b1;
    step();

    // Busy start in ISSUE_DELTA, then reset in WAIT_OUT.
    push_model(2'd2, {12'd4, 12'd3, 12'd2, 12'd1}, 1'b0);
    delta_input_ready = 1'b0;
    delta_output_valid = 1'b0;
    pulse_start(2'd2, {12'd4, 12'd3, 12'd2, 12'd1});
    cyc = 0;
    while (!delta_input_valid && cyc < 20) begin
      step();
      cyc++;
    end
    chk("busy_reach_delta", 64'(delta_input_valid), 64'(1));
    pulse_start(2'd1, {12'hAAA, 12'hBBB, 12'hCCC, 12'hDDD});
    chk("busy_layer_kept", 64'(layer), 64'(2));
    chk("busy_delta_kept", 64'(delta_input), 64'({12'd4, 12'd3, 12'd2, 12'd1}));
    delta_input_ready = 1'b1;
    step();
    chk("busy_in_wait", 64'(delta_output_ready), 64'(1));
    rst = 1'b0;
    #1;
    chk_reset_outs("midreset");
    flush_q();
    step();
    rst = 1'b1;
    delta_output_valid = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (result_valid || !start_ready) ok = 1'b0;
    end
    chk("midreset_no_result", 64'(ok), 64'(1));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/backprop_sequencer.md
# backprop_sequencer

Layer-by-layer scheduler for the `error_propagator` datapath. It accepts a backpropagation pass request (top layer index plus output-layer delta) and runs one propagator pass per layer, from the top layer down to layer 0. On each pass it issues the layer index, then the current delta, collects `delta_output` and hands it to the weight-update side. The low cells of each `delta_output` become the next pass's `delta_input`. `z` and `w` are fetched by the layer memories from the same `layer` handshake and are outside this block.

## Interface
- `MATRIX_WIDTH`, 4, cells in propagator `delta_input`
- `MATRIX_HEIGHT`, 5, cells in propagator `delta_output`; must be ≥ `MATRIX_WIDTH`
- `DELTA_CELL_WIDTH`, 12, bits per delta cell
- `LAYER_ADDR_WIDTH`, 2, layer index width
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  pass request valid
- `start_ready`  out  1  high only in IDLE
- `start_layer`  in  LAYER_ADDR_WIDTH  top layer index; captured on start transfer
- `start_delta`  in  MATRIX_WIDTH*DELTA_CELL_WIDTH  output-layer delta; captured on start transfer
- `layer`  out  LAYER_ADDR_WIDTH  to propagator
- `layer_valid` out 1, `layer_ready` in 1
- `delta_input`  out  MATRIX_WIDTH*DELTA_CELL_WIDTH  to propagator
- `delta_input_valid` out 1, `delta_input_ready` in 1
- `delta_output`  in  MATRIX_HEIGHT*DELTA_CELL_WIDTH  from propagator
- `delta_output_valid` in 1, `delta_output_ready` out 1
- `error`  in  1  propagator error flag
- `result`  out  MATRIX_HEIGHT*DELTA_CELL_WIDTH  captured delta_output
- `result_layer`  out  LAYER_ADDR_WIDTH  layer that produced `result`
- `result_valid` out 1, `result_ready` in 1
- `done`  out  1  one-cycle pulse at end of pass
- `fault`  out  1  sticky error indication

## Operation
- **Handshakes:** all channels are valid/ready. A transfer occurs on a rising edge with both high. The valid side holds data stable until the transfer completes.
- **FSM states:** IDLE, ISSUE_LAYER, ISSUE_DELTA, WAIT_OUT, EMIT, DONE, FAULT.
- **IDLE:** `start_ready`=1. On a start transfer, capture `start_layer` into `cur_layer` and `start_delta` into `cur_delta`, then go to ISSUE_LAYER.
- **ISSUE_LAYER:** `layer`=`cur_layer`, `layer_valid`=1. On transfer, go to ISSUE_DELTA.
- **ISSUE_DELTA:** `delta_input`=`cur_delta`, `delta_input_valid`=1. On transfer, go to WAIT_OUT.
- **WAIT_OUT:** `delta_output_ready`=1. On transfer, register `delta_output` into `result` and `cur_layer` into `result_layer`, then go to EMIT.
- **EMIT:** `result_valid`=1. On transfer:
  - if `cur_layer`==0, go to DONE;
  - otherwise decrement `cur_layer`, set `cur_delta` to the low MATRIX_WIDTH cells of `result` (cell 0 at bit 0, upper cells discarded, no value change), and go to ISSUE_LAYER.
- **DONE:** `done`=1 for one cycle, then go to IDLE.
- **Pass length:** exactly `start_layer`+1 propagator passes per request.
- **Error handling:** `error` high in any state other than IDLE or FAULT forces FAULT on the next edge. FAULT has priority over any simultaneous transfer.
  - In FAULT: `fault`=1 and all valids/readies are 0, including `start_ready`.
  - Only `rst` leaves FAULT.
  - `error` high in IDLE is ignored.

## Timing
- **Reset values:** `start_ready`=1. All other outputs are 0: `layer`, `layer_valid`, `delta_input`, `delta_input_valid`, `delta_output_ready`, `result`, `result_layer`, `result_valid`, `done`, `fault`. FSM is in IDLE.
- **Reset mid-pass:** asynchronous return to the reset state. No partial result is emitted.
- **Output registering:** all outputs are registered or decoded directly from the state register. No combinational path from any input to any output.
- **Minimum latency:** one cycle per state when the partner ready/valid is already high. Start transfer at edge N gives `layer_valid` high after N. The minimum per layer is 4 cycles (ISSUE_LAYER, ISSUE_DELTA, WAIT_OUT, EMIT), plus propagator latency.
- **Early `delta_output_valid`:** while not in WAIT_OUT it is not accepted, because `delta_output_ready`=0.
- **`start` while busy:** ignored. It is neither queued nor captured.
- **Back-pressure:** `result_ready` held low stalls EMIT indefinitely. The next layer is not issued until the result transfers.
- **`done` timing:** asserted for exactly one cycle, the cycle after the last EMIT transfer.

## Configuration
- Macro: `BACKPROP_SEQ_CYCLE_COUNT_EN`.
- **Defined:** adds output `pass_cycles` [15:0].
  - Reset value 0.
  - Cleared on start transfer, then increments every cycle while not in IDLE, DONE or FAULT.
  - Saturates at 16'hFFFF.
  - Holds its value in IDLE, DONE and FAULT.
- **Undefined:** port and counter are absent. Behaviour is otherwise identical.

## Test plan
- **Three-layer pass:** `start_layer`=2, `start_delta`={12'd1,12'd1,12'd1,12'd1}, partner readies/valids always high → `layer` sequence 2,1,0. `result_layer` sequence 2,1,0. `done` pulses once, 13 cycles after the start transfer plus propagator latency.
- **Delta feedback:** return `delta_output` cells {50,40,30,20,10} (cell4..cell0) for layer 1 → next `delta_input`={40,30,20,10}.
- **Single layer:** `start_layer`=0 → one pass, then `done` pulse, then `start_ready`=1 the following cycle.
- **Back-pressure:** hold `result_ready`=0 for 10 cycles in EMIT → `result` stable and no new `layer_valid`. Release → next layer issued one cycle later.
- **Fault:** assert `error` during WAIT_OUT → `fault`=1 next cycle, all valids/readies 0, `start` ignored. `rst` low → `fault`=0, `start_ready`=1.
- **Busy start / reset mid-pass:** pulse `start` in ISSUE_DELTA → ignored. Drop `rst` in WAIT_OUT → all outputs at reset values immediately, no `result_valid`.
